// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared constants for the EX-stage ALU control unit: ALU
//               control codes, ALUOp codes, R-type funct codes, the multiply
//               sequencer state encoding and the ALUOp/funct decode function.
// Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

   // ALU control codes
   localparam logic [3:0] c_alu_and = 4'b0000;
   localparam logic [3:0] c_alu_or  = 4'b0001;
   localparam logic [3:0] c_alu_add = 4'b0010;
   localparam logic [3:0] c_alu_sub = 4'b0110;
   localparam logic [3:0] c_alu_slt = 4'b0111;
   localparam logic [3:0] c_alu_nor = 4'b1100;

   // ALUOp codes from the main control unit
   localparam logic [1:0] c_aluop_add   = 2'b00;
   localparam logic [1:0] c_aluop_sub   = 2'b01;
   localparam logic [1:0] c_aluop_funct = 2'b10;
   localparam logic [1:0] c_aluop_or    = 2'b11;

   // R-type funct codes
   localparam logic [5:0] c_fn_add   = 6'b100000;
   localparam logic [5:0] c_fn_sub   = 6'b100010;
   localparam logic [5:0] c_fn_and   = 6'b100100;
   localparam logic [5:0] c_fn_or    = 6'b100101;
   localparam logic [5:0] c_fn_nor   = 6'b100111;
   localparam logic [5:0] c_fn_slt   = 6'b101010;
   localparam logic [5:0] c_fn_mult  = 6'b011000;
   localparam logic [5:0] c_fn_multu = 6'b011001;
   localparam logic [5:0] c_fn_mfhi  = 6'b010000;
   localparam logic [5:0] c_fn_mflo  = 6'b010010;

   // Multiply sequencer states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // ALUOp/funct to ALU control code. Multiply and HI/LO moves fall into the
   // default (AND) because the ALU result is not used for them.
   function automatic logic [3:0] alu_decode(input logic [1:0] op,
                                             input logic [5:0] fn);
      logic [3:0] code;
      code = c_alu_and;
      case (op)
         c_aluop_add: code = c_alu_add;
         c_aluop_sub: code = c_alu_sub;
         c_aluop_or:  code = c_alu_or;
         default: begin
            case (fn)
               c_fn_add: code = c_alu_add;
               c_fn_sub: code = c_alu_sub;
               c_fn_and: code = c_alu_and;
               c_fn_or:  code = c_alu_or;
               c_fn_nor: code = c_alu_nor;
               c_fn_slt: code = c_alu_slt;
               default:  code = c_alu_and;
            endcase
         end
      endcase
      return code;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mult_seq.sv
`default_nettype none
// ============================================================================
// Module      : mult_seq
// Description : Iterative shift-add multiplier, one multiplier bit per clock.
//               Signed operands are reduced to magnitudes on start and the
//               product sign is restored on the final cycle.
// Ports       : clk, rst        clock, synchronous active-high reset
//               start           load operands and begin (ignored while busy)
//               is_signed       treat a/b as two's complement
//               a, b            WIDTH-bit operands
//               busy            iteration in progress
//               done            final iteration cycle; product valid now
//               product         2*WIDTH-bit signed/unsigned result
// Revision    : 1.0  initial release
// ============================================================================
module mult_seq #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 is_signed,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   logic                 r_busy;
   logic                 r_neg;
   logic [CNT_W-1:0]     r_cnt;
   logic [WIDTH-1:0]     r_mcand;
   logic [WIDTH-1:0]     r_mplier;
   logic [2*WIDTH-1:0]   r_acc;

   logic [WIDTH-1:0]     w_a_mag;
   logic [WIDTH-1:0]     w_b_mag;
   logic [WIDTH:0]       w_sum;
   logic [2*WIDTH-1:0]   w_acc_next;
   logic                 w_acc_lsb_unused;

   // Magnitudes are unsigned WIDTH-bit values, so the most negative operand
   // maps to itself and still multiplies correctly.
   assign w_a_mag = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
   assign w_b_mag = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

   // Upper half plus optional multiplicand; the extra sum bit carries into
   // the shifted accumulator.
   assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                       {1'b0, (r_mplier[0] ? r_mcand : {WIDTH{1'b0}})};
   assign w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
   assign w_acc_lsb_unused = r_acc[0];

   assign busy    = r_busy;
   assign done    = r_busy && (r_cnt == CNT_W'(WIDTH-1));
   // Product is taken from the last iteration's next value so the caller can
   // capture it on the same edge that ends the multiply.
   assign product = r_neg ? (~w_acc_next + (2*WIDTH)'(1)) : w_acc_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy   <= 1'b0;
         r_neg    <= 1'b0;
         r_cnt    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
      end else if (start && !r_busy) begin
         r_busy   <= 1'b1;
         r_neg    <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
         r_cnt    <= '0;
         r_mcand  <= w_a_mag;
         r_mplier <= w_b_mag;
         r_acc    <= '0;
      end else if (r_busy) begin
         r_acc    <= w_acc_next;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + CNT_W'(1);
         if (done) begin
            r_busy <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/alu_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_seq
// Description : EX-stage ALU control producer. Decodes ALUOp/funct into the
//               4-bit ALU control code and, when ALU_CTRL_MULT_EN is defined,
//               implements mult/multu/mfhi/mflo with HI/LO registers and an
//               iterative multiplier that stalls the pipeline while running.
// Build macro : ALU_CTRL_MULT_EN  (undefined: no multiplier, stall/hi/lo = 0)
// Ports       : clk, rst         clock, synchronous active-high reset
//               valid            EX instruction valid
//               alu_op, funct    control inputs for decode
//               rs_val, rt_val   multiply operands
//               alu_control      ALU control code
//               stall            hold PC, IF/ID and EX instruction
//               hilo_rd          mfhi/mflo in EX
//               hilo_rdata       HI (mfhi) or LO (mflo)
//               hi, lo           HI/LO registers
// Revision    : 1.0  initial release
// ============================================================================
module alu_ctrl_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               valid,
   input  logic [1:0]         alu_op,
   input  logic [5:0]         funct,
   input  logic [WIDTH-1:0]   rs_val,
   input  logic [WIDTH-1:0]   rt_val,
   output logic [3:0]         alu_control,
   output logic               stall,
   output logic               hilo_rd,
   output logic [WIDTH-1:0]   hilo_rdata,
   output logic [WIDTH-1:0]   hi,
   output logic [WIDTH-1:0]   lo
);

   logic w_rtype;

   assign alu_control = alu_decode(alu_op, funct);
   assign w_rtype     = valid && (alu_op == c_aluop_funct);
   assign hilo_rd     = w_rtype && ((funct == c_fn_mfhi) || (funct == c_fn_mflo));

`ifdef ALU_CTRL_MULT_EN

   state_t               r_state;
   state_t               w_state_next;
   logic                 w_is_mul;
   logic                 w_start;
   logic                 w_stall;
   logic                 w_busy;
   logic                 w_done;
   logic [2*WIDTH-1:0]   w_product;
   logic [WIDTH-1:0]     r_hi;
   logic [WIDTH-1:0]     r_lo;

   assign w_is_mul = w_rtype && ((funct == c_fn_mult) || (funct == c_fn_multu));

   mult_seq #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_mult_seq (
      .clk       (clk),
      .rst       (rst),
      .start     (w_start),
      .is_signed (funct == c_fn_mult),
      .a         (rs_val),
      .b         (rt_val),
      .busy      (w_busy),
      .done      (w_done),
      .product   (w_product)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_hi    <= '0;
         r_lo    <= '0;
      end else begin
         r_state <= w_state_next;
         if ((r_state == ST_MUL) && w_done) begin
            {r_hi, r_lo} <= w_product;
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_start      = 1'b0;
      w_stall      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_is_mul) begin
               w_start      = 1'b1;
               w_stall      = 1'b1;
               w_state_next = ST_MUL;
            end
         end
         ST_MUL: begin
            w_stall = 1'b1;
            if (w_done) begin
               w_state_next = ST_DONE;
            end else if (!w_busy) begin
               w_state_next = ST_IDLE;
            end
         end
         // The held multiply retires here; valid is deliberately ignored so
         // the same instruction does not restart the multiplier.
         ST_DONE: w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Reset releases the pipeline in the same cycle it is asserted.
   assign stall      = w_stall && !rst;
   assign hi         = r_hi;
   assign lo         = r_lo;
   assign hilo_rdata = (funct == c_fn_mfhi) ? r_hi : r_lo;

`else

   logic w_mult_unused;

   assign w_mult_unused = &{1'b0, clk, rst, rs_val, rt_val};
   assign stall         = 1'b0;
   assign hi            = '0;
   assign lo            = '0;
   assign hilo_rdata    = '0;

`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_ctrl_seq
// Description : Self-checking bench for alu_ctrl_seq. Decode is compared
//               against the control-code table; multiplies against 64-bit
//               arithmetic. Multiply scenarios run when ALU_CTRL_MULT_EN is
//               defined, otherwise the tied-off behaviour is checked.
// Revision    : 1.0  initial release
// ============================================================================
module tb_alu_ctrl_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic [1:0]  alu_op;
   logic [5:0]  funct;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic [3:0]  alu_control;
   logic        stall;
   logic        hilo_rd;
   logic [31:0] hilo_rdata;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   alu_ctrl_seq #(.WIDTH(32), .CNT_W(5)) dut (
      .clk         (clk),
      .rst         (rst),
      .valid       (valid),
      .alu_op      (alu_op),
      .funct       (funct),
      .rs_val      (rs_val),
      .rt_val      (rt_val),
      .alu_control (alu_control),
      .stall       (stall),
      .hilo_rd     (hilo_rd),
      .hilo_rdata  (hilo_rdata),
      .hi          (hi),
      .lo          (lo)
   );

   always #5 clk = ~clk;

   // Reference decode table
   function automatic logic [3:0] ref_ctrl(input logic [1:0] op, input logic [5:0] fn);
      if (op == 2'b00) return 4'b0010;
      if (op == 2'b01) return 4'b0110;
      if (op == 2'b11) return 4'b0001;
      case (fn)
         6'b100000: return 4'b0010;
         6'b100010: return 4'b0110;
         6'b100100: return 4'b0000;
         6'b100101: return 4'b0001;
         6'b100111: return 4'b1100;
         6'b101010: return 4'b0111;
         default:   return 4'b0000;
      endcase
   endfunction

   function automatic logic [63:0] ref_prod(input bit sgn, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      if (!sgn) return {32'd0, a} * {32'd0, b};
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
   endfunction

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; valid = 1'b0; alu_op = 2'b00; funct = 6'd0; rs_val = '0; rt_val = '0;
      @(posedge clk); #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
      checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h expected 0", hi); end
      checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h expected 0", lo); end
      @(negedge clk);
      rst = 1'b0;
      m_hi = '0; m_lo = '0;
   endtask

   task automatic test_decode();
      logic [5:0] fns [7];
      logic [1:0] ops [3];
      logic       exp_rd;
      fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010, 6'b111111};
      ops = '{2'b00, 2'b01, 2'b11};
      foreach (fns[i]) begin
         @(negedge clk);
         valid = 1'b1; alu_op = 2'b10; funct = fns[i]; #1;
         checks++;
         if (alu_control !== ref_ctrl(2'b10, fns[i])) begin
            errors++; $display("FAIL decode_funct_%b: got %b expected %b", fns[i], alu_control, ref_ctrl(2'b10, fns[i]));
         end
      end
      foreach (ops[i]) begin
         @(negedge clk);
         valid = 1'b1; alu_op = ops[i]; funct = 6'($urandom); #1;
         checks++;
         if (alu_control !== ref_ctrl(ops[i], funct)) begin
            errors++; $display("FAIL decode_op_%b: got %b expected %b", ops[i], alu_control, ref_ctrl(ops[i], funct));
         end
      end
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         alu_op = 2'($urandom_range(0, 3));
         funct  = ($urandom_range(0, 1) == 0) ? fns[$urandom_range(0, 6)] : 6'($urandom);
         valid  = 1'($urandom);
         // Keep multiplies out of the decode sweep so no sequence starts.
         if (alu_op == 2'b10 && (funct == 6'b011000 || funct == 6'b011001)) valid = 1'b0;
         #1;
         exp_rd = valid && alu_op == 2'b10 && (funct == 6'b010000 || funct == 6'b010010);
         checks++;
         if (alu_control !== ref_ctrl(alu_op, funct)) begin
            errors++; $display("FAIL decode_rand op=%b fn=%b: got %b expected %b", alu_op, funct, alu_control, ref_ctrl(alu_op, funct));
         end
         checks++;
         if (hilo_rd !== exp_rd) begin
            errors++; $display("FAIL hilo_rd_rand op=%b fn=%b v=%b: got %b expected %b", alu_op, funct, valid, hilo_rd, exp_rd);
         end
      end
      @(negedge clk);
      valid = 1'b0;
   endtask

   task automatic test_hilo_read(input string name);
      @(negedge clk);
      valid = 1'b1; alu_op = 2'b10; funct = 6'b010000; #1;
      checks++;
      if (hilo_rd !== 1'b1 || hilo_rdata !== m_hi) begin
         errors++; $display("FAIL %s_mfhi: got rd=%b data=%h expected rd=1 data=%h", name, hilo_rd, hilo_rdata, m_hi);
      end
      @(negedge clk);
      funct = 6'b010010; #1;
      checks++;
      if (hilo_rd !== 1'b1 || hilo_rdata !== m_lo) begin
         errors++; $display("FAIL %s_mflo: got rd=%b data=%h expected rd=1 data=%h", name, hilo_rd, hilo_rdata, m_lo);
      end
      @(negedge clk);
      valid = 1'b0;
   endtask

`ifdef ALU_CTRL_MULT_EN

   // Issues one multiply, counts stalled cycles and returns in the DONE cycle.
   task automatic do_mul(input bit sgn, input logic [31:0] a, input logic [31:0] b, input string name);
      logic [63:0] exp;
      int          n;
      exp = ref_prod(sgn, a, b);
      @(negedge clk);
      valid = 1'b1; alu_op = 2'b10; funct = sgn ? 6'b011000 : 6'b011001; rs_val = a; rt_val = b;
      #1;
      n = 0;
      for (int i = 0; i < 200; i++) begin
         if (stall !== 1'b1) break;
         n++;
         @(negedge clk); #1;
      end
      checks++;
      if (n != 33) begin errors++; $display("FAIL %s_stall_cycles: got %0d expected 33", name, n); end
      checks++;
      if ({hi, lo} !== exp) begin errors++; $display("FAIL %s_product: got %h_%h expected %h", name, hi, lo, exp); end
      checks++;
      if (alu_control !== 4'b0000) begin errors++; $display("FAIL %s_alu_control: got %b expected 0000", name, alu_control); end
      m_hi = exp[63:32];
      m_lo = exp[31:0];
   endtask

   task automatic test_mult_corners();
      do_mul(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max");
      checks++;
      if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
         errors++; $display("FAIL multu_max_const: got %h_%h expected fffffffe_00000001", hi, lo);
      end
      test_hilo_read("multu_max");
      do_mul(1'b1, 32'hFFFFFFFD, 32'd7, "mult_neg3x7");
      checks++;
      if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) begin
         errors++; $display("FAIL mult_neg3x7_const: got %h_%h expected ffffffff_ffffffeb", hi, lo);
      end
      test_hilo_read("mult_neg3x7");
      do_mul(1'b1, 32'h80000000, 32'h80000000, "mult_minsq");
      checks++;
      if (hi !== 32'h40000000 || lo !== 32'h00000000) begin
         errors++; $display("FAIL mult_minsq_const: got %h_%h expected 40000000_00000000", hi, lo);
      end
      @(negedge clk);
      valid = 1'b0;
   endtask

   task automatic test_mult_random();
      for (int n = 0; n < 6; n++) begin
         do_mul(1'($urandom), $urandom, $urandom, "mult_rand");
         test_hilo_read("mult_rand");
      end
   endtask

   task automatic test_back_to_back();
      do_mul(1'b1, 32'd5, 32'd6, "b2b_first");
      checks++;
      if (lo !== 32'd30 || hi !== 32'd0) begin errors++; $display("FAIL b2b_mid_lo: got %h_%h expected 0_1e", hi, lo); end
      do_mul(1'b0, 32'd2, 32'd3, "b2b_second");
      checks++;
      if (lo !== 32'd6 || hi !== 32'd0) begin errors++; $display("FAIL b2b_final: got %h_%h expected 0_6", hi, lo); end
      @(negedge clk);
      valid = 1'b0;
   endtask

   task automatic test_reset_mid_mul();
      @(negedge clk);
      valid = 1'b1; alu_op = 2'b10; funct = 6'b011001; rs_val = 32'h1234; rt_val = 32'h10;
      repeat (11) @(negedge clk);
      #1;
      checks++;
      if (stall !== 1'b1) begin errors++; $display("FAIL abort_pre_stall: got %b expected 1", stall); end
      rst = 1'b1; valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (stall !== 1'b0) begin errors++; $display("FAIL abort_stall: got %b expected 0", stall); end
      checks++;
      if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL abort_hilo: got %h_%h expected 0_0", hi, lo); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (stall !== 1'b0) begin errors++; $display("FAIL abort_idle_stall: got %b expected 0", stall); end
      m_hi = '0; m_lo = '0;
      do_mul(1'b0, 32'd4, 32'd4, "after_abort");
      checks++;
      if (lo !== 32'd16) begin errors++; $display("FAIL after_abort_lo: got %h expected 10", lo); end
      @(negedge clk);
      valid = 1'b0;
   endtask

`else

   task automatic test_no_mult();
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         valid = 1'b1; alu_op = 2'b10;
         funct = ($urandom_range(0, 1) == 0) ? 6'b011000 : 6'b011001;
         rs_val = $urandom; rt_val = $urandom;
         #1;
         checks++;
         if (stall !== 1'b0) begin errors++; $display("FAIL nomult_stall: got %b expected 0", stall); end
         checks++;
         if (alu_control !== 4'b0000) begin errors++; $display("FAIL nomult_alu_control: got %b expected 0000", alu_control); end
         checks++;
         if (hi !== 32'd0 || lo !== 32'd0 || hilo_rdata !== 32'd0) begin
            errors++; $display("FAIL nomult_hilo: got hi=%h lo=%h rdata=%h expected 0", hi, lo, hilo_rdata);
         end
      end
      test_hilo_read("nomult");
   endtask

`endif

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; valid = 1'b0; alu_op = 2'b00; funct = 6'd0; rs_val = '0; rt_val = '0;
      repeat (2) @(posedge clk);
      test_reset();
      test_decode();
      test_hilo_read("after_reset");
`ifdef ALU_CTRL_MULT_EN
      test_mult_corners();
      test_mult_random();
      test_back_to_back();
      test_reset_mid_mul();
`else
      test_no_mult();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
